// File: rtl/flash_readback.sv
// flash_readback: ping-pong buffered SPI flash read-back streamed out a UART tx pin (8N1).
// Optional FLASH_READBACK_CHECKSUM_EN appends a mod-256 sum trailer byte after the data.
module flash_readback #(
  parameter int CLKS_PER_BIT = 104,
  parameter int BLOCK_SIZE   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [23:0] length,
  output logic        busy,
  output logic        done,
  output logic        spi_req,
  output logic [23:0] spi_addr,
  output logic [8:0]  spi_len,
  input  logic        spi_ack,
  input  logic        spi_valid,
  input  logic [7:0]  spi_data,
  output logic        tx
);

  localparam int AW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [23:0] BS = 24'(BLOCK_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    WAIT_BUF,
    FLUSH,
    FINISH
  } state_t;

  state_t state;

  logic [7:0]  mem [2][2**AW];
  logic [1:0]  full;
  logic [8:0]  blen [2];
  logic        fill_sel;
  logic [8:0]  fill_idx;
  logic [23:0] cur_addr;
  logic [23:0] remaining;

  logic        fill_wr;
  logic        fill_last;
  logic        xfer_start;
  logic [23:0] rem_next;
  logic [23:0] addr_next;
  logic [1:0]  set_full;
  logic [1:0]  clr_full;

  logic          tx_busy;
  logic          tx_buf;
  logic          tx_sel;
  logic [8:0]    tx_idx;
  logic [8:0]    nxt_idx;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] clk_cnt;
  logic [8:0]    shreg;
  logic          bit_end;
  logic          frame_end;
  logic          blk_end;

`ifdef FLASH_READBACK_CHECKSUM_EN
  logic [7:0] sum;
  logic       csum_go;
  logic       csum_sent;
`endif

  function automatic logic [8:0] blk(input logic [23:0] r);
    return (r >= BS) ? BS[8:0] : r[8:0];
  endfunction

  assign xfer_start = (state == IDLE) && start;
  assign fill_wr    = (state == FILL) && spi_valid;
  assign fill_last  = fill_wr && (fill_idx == spi_len - 9'd1);
  assign rem_next   = remaining - {15'd0, spi_len};
  assign addr_next  = cur_addr + {15'd0, spi_len};
  assign set_full   = fill_last ? (2'b01 << fill_sel) : 2'b00;

  assign nxt_idx   = tx_idx + 9'd1;
  assign bit_end   = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign frame_end = tx_busy && bit_end && (bit_cnt == 4'd9);
  assign blk_end   = frame_end && tx_buf &&
                     (tx_idx == blen[tx_sel] - 9'd1);
  assign clr_full  = blk_end ? (2'b01 << tx_sel) : 2'b00;

  // Buffer storage carries no reset; the full flags alone say what is valid.
  always_ff @(posedge clk) begin
    if (fill_wr) mem[fill_sel][fill_idx[AW-1:0]] <= spi_data;
  end

  always_ff @(posedge clk) begin
    if (rst) full <= 2'b00;
    else     full <= (full | set_full) & ~clr_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_req   <= 1'b0;
      spi_addr  <= 24'd0;
      spi_len   <= 9'd0;
      fill_sel  <= 1'b0;
      fill_idx  <= 9'd0;
      cur_addr  <= 24'd0;
      remaining <= 24'd0;
      blen[0]   <= 9'd0;
      blen[1]   <= 9'd0;
`ifdef FLASH_READBACK_CHECKSUM_EN
      sum       <= 8'd0;
      csum_go   <= 1'b0;
      csum_sent <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef FLASH_READBACK_CHECKSUM_EN
      csum_go <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= length;
            fill_sel  <= 1'b0;
`ifdef FLASH_READBACK_CHECKSUM_EN
            sum       <= 8'd0;
            csum_sent <= 1'b0;
`endif
            if (length == 24'd0) begin
`ifdef FLASH_READBACK_CHECKSUM_EN
              state <= FLUSH;
              busy  <= 1'b1;
`else
              state <= FINISH;
              done  <= 1'b1;
`endif
            end else begin
              state    <= REQ;
              busy     <= 1'b1;
              spi_req  <= 1'b1;
              spi_addr <= base_addr;
              spi_len  <= blk(length);
            end
          end
        end
        REQ: begin
          if (spi_ack) begin
            spi_req  <= 1'b0;
            fill_idx <= 9'd0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (fill_wr) begin
            fill_idx <= fill_idx + 9'd1;
`ifdef FLASH_READBACK_CHECKSUM_EN
            sum <= sum + spi_data;
`endif
            if (fill_last) begin
              blen[fill_sel] <= spi_len;
              fill_sel       <= ~fill_sel;
              cur_addr       <= addr_next;
              remaining      <= rem_next;
              if (rem_next == 24'd0) begin
                state <= FLUSH;
              end else if (full[~fill_sel]) begin
                state <= WAIT_BUF;
              end else begin
                state    <= REQ;
                spi_req  <= 1'b1;
                spi_addr <= addr_next;
                spi_len  <= blk(rem_next);
              end
            end
          end
        end
        WAIT_BUF: begin
          if (!full[fill_sel]) begin
            state    <= REQ;
            spi_req  <= 1'b1;
            spi_addr <= cur_addr;
            spi_len  <= blk(remaining);
          end
        end
        FLUSH: begin
`ifdef FLASH_READBACK_CHECKSUM_EN
          // csum_go guards the cycle before the transmitter picks up the trailer
          if (full == 2'b00 && !tx_busy && !csum_go) begin
            if (!csum_sent) begin
              csum_go   <= 1'b1;
              csum_sent <= 1'b1;
            end else begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
`else
          if (full == 2'b00 && !tx_busy) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_buf  <= 1'b0;
      tx_sel  <= 1'b0;
      tx_idx  <= 9'd0;
      bit_cnt <= 4'd0;
      clk_cnt <= '0;
      shreg   <= '1;
    end else if (!tx_busy) begin
      if (xfer_start) begin
        tx_sel <= 1'b0;
      end else if (full[tx_sel]) begin
        tx      <= 1'b0;
        shreg   <= {1'b1, mem[tx_sel]['0]};
        tx_busy <= 1'b1;
        tx_buf  <= 1'b1;
        tx_idx  <= 9'd0;
        bit_cnt <= 4'd0;
        clk_cnt <= '0;
`ifdef FLASH_READBACK_CHECKSUM_EN
      end else if (csum_go) begin
        tx      <= 1'b0;
        shreg   <= {1'b1, sum};
        tx_busy <= 1'b1;
        tx_buf  <= 1'b0;
        bit_cnt <= 4'd0;
        clk_cnt <= '0;
`endif
      end
    end else if (bit_end) begin
      clk_cnt <= '0;
      if (bit_cnt != 4'd9) begin
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end else if (tx_buf && !blk_end) begin
        tx      <= 1'b0;
        shreg   <= {1'b1, mem[tx_sel][nxt_idx[AW-1:0]]};
        tx_idx  <= nxt_idx;
        bit_cnt <= 4'd0;
      end else if (tx_buf && full[~tx_sel]) begin
        // chain straight into the other buffer so blocks stream gap-free
        tx      <= 1'b0;
        shreg   <= {1'b1, mem[~tx_sel]['0]};
        tx_sel  <= ~tx_sel;
        tx_idx  <= 9'd0;
        bit_cnt <= 4'd0;
      end else begin
        tx      <= 1'b1;
        tx_busy <= 1'b0;
        if (tx_buf) tx_sel <= ~tx_sel;
      end
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_readback.sv
// tb_flash_readback: scoreboard bench for flash_readback with a flash model
// and a UART receiver; expected requests and bytes are queued at stimulus time.
module tb_flash_readback;

  localparam int CPB = 3;
  localparam int BS  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] base_addr;
  logic [23:0] length;
  logic        busy;
  logic        done;
  logic        spi_req;
  logic [23:0] spi_addr;
  logic [8:0]  spi_len;
  logic        spi_ack;
  logic        spi_valid;
  logic [7:0]  spi_data;
  logic        tx;

  always #5 clk = ~clk;

  flash_readback #(
    .CLKS_PER_BIT(CPB),
    .BLOCK_SIZE(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .spi_req(spi_req),
    .spi_addr(spi_addr),
    .spi_len(spi_len),
    .spi_ack(spi_ack),
    .spi_valid(spi_valid),
    .spi_data(spi_data),
    .tx(tx)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  exp_byte [$];
  logic [23:0] exp_addr [$];
  logic [8:0]  exp_len [$];

  int rx_total = 0;
  int xfer_rx_base = 0;
  int cur_len = 0;
  int xfer_id = 0;
  int junk_req = 0;
  bit mon_en = 1'b0;
  bit xtra = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fdata(input logic [23:0] a);
    case (a)
      24'h000100: return 8'hA5;
      24'h000101: return 8'h01;
      24'h000102: return 8'hFF;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  // UART receiver: samples mid-bit on the falling clock edge
  initial begin : mon
    bit inf;
    int mc;
    int idx;
    int last_start;
    logic [7:0] sh;
    inf = 1'b0;
    mc = 0;
    last_start = 0;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        inf = 1'b0;
      end else if (!inf) begin
        if (tx === 1'b0) begin
          inf = 1'b1;
          mc = 0;
          idx = rx_total - xfer_rx_base;
          if (idx > 0 && idx < cur_len)
            check("gap", cyc - last_start, 10 * CPB);
          last_start = cyc;
        end
      end else begin
        mc++;
        for (int j = 1; j <= 8; j++)
          if (mc == j * CPB + CPB / 2) sh[j-1] = tx;
        if (mc == 9 * CPB + CPB / 2) begin
          inf = 1'b0;
          check("stop_bit", {31'd0, tx}, 1);
          if (exp_byte.size() == 0)
            check("rx_extra", {24'd0, sh}, 32'h100);
          else
            check("rx_byte", {24'd0, sh}, {24'd0, exp_byte.pop_front()});
          rx_total++;
        end
      end
    end
  end

  // SPI flash read model
  initial begin : flash
    int st;
    int fc;
    int ridx;
    int lid;
    int jd;
    int need;
    int rl [64];
    logic [23:0] fa;
    st = 0; fc = 0; ridx = 0; lid = 0; jd = 0; fa = 24'd0;
    spi_ack = 1'b0;
    spi_valid = 1'b0;
    spi_data = 8'h00;
    forever begin
      @(negedge clk);
      spi_ack = 1'b0;
      spi_valid = 1'b0;
      if (lid != xfer_id) begin
        lid = xfer_id;
        ridx = 0;
      end
      if (rst) begin
        st = 0;
      end else if (jd != junk_req) begin
        jd++;
        spi_valid = 1'b1;
        spi_data = 8'hEE;
      end else if (st == 0) begin
        if (spi_req) begin
          if (exp_addr.size() == 0) begin
            check("req_extra", {8'd0, spi_addr}, 32'hFFFFFFFF);
          end else begin
            check("req_addr", {8'd0, spi_addr}, {8'd0, exp_addr.pop_front()});
            check("req_len", {23'd0, spi_len}, {23'd0, exp_len.pop_front()});
          end
          if (ridx >= 2 && ridx < 64) begin
            need = 0;
            for (int k = 0; k < ridx - 1; k++) need += rl[k];
            check("wait_buf", {31'd0, (rx_total - xfer_rx_base) >= need}, 1);
          end
          if (ridx < 64) rl[ridx] = int'(spi_len);
          ridx++;
          spi_ack = 1'b1;
          fa = spi_addr;
          fc = int'(spi_len);
          st = 1;
        end
      end else if (st == 1) begin
        spi_valid = 1'b1;
        spi_data = fdata(fa);
        fa = fa + 24'd1;
        fc--;
        if (fc == 0) st = xtra ? 2 : 0;
      end else begin
        spi_valid = 1'b1;
        spi_data = 8'h77;
        st = 0;
      end
    end
  end

  task automatic push_expect(input logic [23:0] b, input logic [23:0] l);
    logic [23:0] a;
    logic [23:0] r;
    logic [8:0]  n;
    logic [7:0]  d;
`ifdef FLASH_READBACK_CHECKSUM_EN
    logic [7:0]  s;
    s = 8'd0;
`endif
    a = b;
    r = l;
    while (r != 24'd0) begin
      n = (r > 24'(BS)) ? 9'(BS) : r[8:0];
      exp_addr.push_back(a);
      exp_len.push_back(n);
      a = a + {15'd0, n};
      r = r - {15'd0, n};
    end
    for (int i = 0; i < int'(l); i++) begin
      d = fdata(b + 24'(i));
      exp_byte.push_back(d);
`ifdef FLASH_READBACK_CHECKSUM_EN
      s = s + d;
`endif
    end
`ifdef FLASH_READBACK_CHECKSUM_EN
    exp_byte.push_back(s);
`endif
    cur_len = int'(l);
    xfer_rx_base = rx_total;
    xfer_id++;
  endtask

  task automatic run_xfer(input logic [23:0] b, input logic [23:0] l,
                          input bit hit_busy);
    bit seen;
    push_expect(b, l);
    base_addr = b;
    length = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base_addr = 24'hABCDEF;
    length = 24'h000007;
`ifdef FLASH_READBACK_CHECKSUM_EN
    check("busy_on", {31'd0, busy}, 1);
`else
    if (l == 24'd0) begin
      check("len0_done", {31'd0, done}, 1);
      check("len0_busy", {31'd0, busy}, 0);
    end else begin
      check("busy_on", {31'd0, busy}, 1);
    end
`endif
    if (hit_busy) begin
      repeat (4) @(negedge clk);
      base_addr = 24'h123456;
      length = 24'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 60000 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", {31'd0, seen}, 1);
    check("bytes_left", exp_byte.size(), 0);
    check("reqs_left", exp_addr.size(), 0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 0);
    check("busy_off", {31'd0, busy}, 0);
    check("tx_idle", {31'd0, tx}, 1);
  endtask

  initial begin : main
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    base_addr = 24'd0;
    length = 24'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_req", {31'd0, spi_req}, 0);
    check("rst_addr", {8'd0, spi_addr}, 0);
    check("rst_len", {23'd0, spi_len}, 0);
    check("rst_tx", {31'd0, tx}, 1);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    run_xfer(24'h000000, 24'd0, 1'b0);
    run_xfer(24'h000100, 24'd3, 1'b0);
    run_xfer(24'h000000, 24'd600, 1'b0);
    run_xfer(24'hFFFF80, 24'd256, 1'b0);
    run_xfer(24'hFFFF80, 24'd300, 1'b0);

    // reset in the middle of the first frame, then replay
    mon_en = 1'b0;
    push_expect(24'h000400, 24'd20);
    base_addr = 24'h000400;
    length = 24'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (tx === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    check("t5_tx_start", {31'd0, seen}, 1);
    repeat (5 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tx", {31'd0, tx}, 1);
    check("t5_req", {31'd0, spi_req}, 0);
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_done", {31'd0, done}, 0);
    rst = 1'b0;
    exp_byte.delete();
    exp_addr.delete();
    exp_len.delete();
    @(negedge clk);
    mon_en = 1'b1;
    run_xfer(24'h000400, 24'd20, 1'b0);

    // stray strobes in IDLE/REQ and past spi_len, start while busy
    junk_req++;
    repeat (3) @(negedge clk);
    junk_req++;
    repeat (3) @(negedge clk);
    xtra = 1'b1;
    run_xfer(24'h000500, 24'd300, 1'b1);
    xtra = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
